// File: rtl/nios_sysid_pkg.sv
// Shared types and constants for the SYSID checker: FSM states, slave word addresses,
// data width and the expected-value bundle.
package nios_sysid_pkg;

  localparam int unsigned SYSID_WORD_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } sysid_chk_state_t;

  // Build values the slave is expected to return at each address.
  typedef struct packed {
    logic [SYSID_WORD_W-1:0] id;
    logic [SYSID_WORD_W-1:0] ts;
  } sysid_expect_t;

endpackage : nios_sysid_pkg

// File: rtl/nios_sysid_wait_timer.sv
// Stall counter for one Avalon read: counts waitrequest cycles and flags the edge on which
// the read has been stalled for TIMEOUT_CYCLES cycles.
module nios_sysid_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned     CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_STALL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("nios_sysid_wait_timer: TIMEOUT_CYCLES must be >= 1");
  end

  // Saturates at TIMEOUT_CYCLES; the owner clears it on every issue and accept.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_en && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Fires on the stall edge that would bring the count to TIMEOUT_CYCLES, so the read
  // strobe is dropped on that same edge and never exceeds TIMEOUT_CYCLES stalled cycles.
  assign expired = count_en && (r_count == LAST_STALL);

endmodule : nios_sysid_wait_timer

// File: rtl/nios_sysid_checker.sv
// Avalon-MM master that reads the SYSID slave ID word (and, with SYSID_TIMESTAMP_CHECK_EN
// defined, the timestamp word) on request and reports pass / fail / timeout.
module nios_sysid_checker
  import nios_sysid_pkg::*;
#(
  parameter logic [SYSID_WORD_W-1:0] EXPECTED_ID        = 32'd0,
  parameter logic [SYSID_WORD_W-1:0] EXPECTED_TIMESTAMP = 32'd1473075641,
  parameter int unsigned             TIMEOUT_CYCLES     = 256
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic                    avm_waitrequest,
  input  logic [SYSID_WORD_W-1:0] avm_readdata,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic [SYSID_WORD_W-1:0] id_value,
  output logic [SYSID_WORD_W-1:0] ts_value
);

  localparam sysid_expect_t EXPECT = '{id: EXPECTED_ID, ts: EXPECTED_TIMESTAMP};

  sysid_chk_state_t        r_state;
  logic                    r_avm_address;
  logic                    r_avm_read;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_pass;
  logic                    r_fail;
  logic                    r_timeout;
  logic [SYSID_WORD_W-1:0] r_id_value;
`ifdef SYSID_TIMESTAMP_CHECK_EN
  logic [SYSID_WORD_W-1:0] r_ts_value;
`endif

  logic w_issue;
  logic w_accept;
  logic w_stall;
  logic w_timer_clear;
  logic w_expired;

  // Handshake decode: accept and stall are only meaningful while our strobe is up.
  assign w_issue       = (r_state == IDLE) && start;
  assign w_accept      = r_avm_read && !avm_waitrequest;
  assign w_stall       = r_avm_read && avm_waitrequest;
  assign w_timer_clear = w_issue || w_accept;

  nios_sysid_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (w_timer_clear),
    .count_en (w_stall),
    .expired  (w_expired)
  );

  // Check sequencer; address and strobe only change on issue, accept or expiry, so they
  // stay stable for the whole time the slave holds waitrequest.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_avm_address <= SYSID_ADDR_ID;
      r_avm_read    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
      r_id_value    <= '0;
`ifdef SYSID_TIMESTAMP_CHECK_EN
      r_ts_value    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state       <= RD_ID;
            r_avm_address <= SYSID_ADDR_ID;
            r_avm_read    <= 1'b1;
            r_busy        <= 1'b1;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_id_value    <= '0;
`ifdef SYSID_TIMESTAMP_CHECK_EN
            r_ts_value    <= '0;
`endif
          end
        end

        RD_ID: begin
          if (w_accept) begin
            r_id_value <= avm_readdata;
            if (avm_readdata != EXPECT.id) begin
              // Wrong ID: the timestamp read is pointless, finish immediately.
              r_state    <= DONE;
              r_avm_read <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_fail     <= 1'b1;
            end else begin
`ifdef SYSID_TIMESTAMP_CHECK_EN
              // Strobe stays high: back-to-back read of the timestamp word.
              r_state       <= RD_TS;
              r_avm_address <= SYSID_ADDR_TS;
`else
              r_state    <= DONE;
              r_avm_read <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_pass     <= 1'b1;
`endif
            end
          end else if (w_expired) begin
            r_state    <= DONE;
            r_avm_read <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_fail     <= 1'b1;
            r_timeout  <= 1'b1;
          end
        end

`ifdef SYSID_TIMESTAMP_CHECK_EN
        RD_TS: begin
          if (w_accept) begin
            r_state       <= DONE;
            r_avm_address <= SYSID_ADDR_ID;
            r_avm_read    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_ts_value    <= avm_readdata;
            r_pass        <= (avm_readdata == EXPECT.ts);
            r_fail        <= (avm_readdata != EXPECT.ts);
          end else if (w_expired) begin
            r_state       <= DONE;
            r_avm_address <= SYSID_ADDR_ID;
            r_avm_read    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_fail        <= 1'b1;
            r_timeout     <= 1'b1;
          end
        end
`endif

        // One idle cycle after completion; start is deliberately ignored here.
        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign avm_address = r_avm_address;
  assign avm_read    = r_avm_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign id_value    = r_id_value;
`ifdef SYSID_TIMESTAMP_CHECK_EN
  assign ts_value    = r_ts_value;
`else
  assign ts_value    = '0;
`endif

endmodule : nios_sysid_checker
